// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_ID_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_RESP = ST_RESP,
    S_DONE = ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Valid/ready data-memory port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_write;
  logic [DATA_WIDTH-1:0] dmem_req_addr;
  logic [DATA_WIDTH-1:0] dmem_req_wdata;
  logic                  dmem_resp_valid;
  logic [DATA_WIDTH-1:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// RESP-state wait counter; expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles since the last clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = enable & (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory port and owns the MEM/WB latch.
// Optional RESP timeout with sticky bus_error is built when DMEM_TIMEOUT_EN is defined.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_enable_in,
  input  logic                  mem_enable_in,
  input  logic                  mem_write_in,
  input  logic                  is_halted_in,
  input  logic [DATA_WIDTH-1:0] alu_output_in,
  input  logic [DATA_WIDTH-1:0] rs2_in,
  input  logic [REG_ID_W-1:0]   rd_id_in,
  mem_access_stage_if.master    dmem,
  output logic                  mem_stall,
  output logic                  wb_enable,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_ID_W-1:0]   rd_id,
  output logic                  is_halted,
  output logic                  bus_error
);
  mem_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_write;
  logic                  r_wb_lat;
  logic                  r_halt_lat;
  logic [REG_ID_W-1:0]   r_rd_lat;
  logic                  r_wb_enable;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [REG_ID_W-1:0]   r_rd_id;
  logic                  r_is_halted;
  logic                  w_expired;

`ifdef DMEM_TIMEOUT_EN
  logic w_to_clear;
  logic w_to_enable;
  logic r_bus_error;

  assign w_to_clear  = (r_state == S_REQ) & dmem.dmem_req_ready & ~r_write;
  assign w_to_enable = (r_state == S_RESP);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_to_clear),
    .enable (w_to_enable),
    .expired(w_expired)
  );

  // Sticky error: a response arriving on the expiry cycle still wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_error <= 1'b0;
    end else if ((r_state == S_RESP) & ~dmem.dmem_resp_valid & w_expired) begin
      r_bus_error <= 1'b1;
    end else begin
      r_bus_error <= r_bus_error;
    end
  end

  assign bus_error = r_bus_error;
`else
  assign w_expired = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Access FSM, request latches and MEM/WB latch; MEM/WB defaults to a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_write     <= 1'b0;
      r_wb_lat    <= 1'b0;
      r_halt_lat  <= 1'b0;
      r_rd_lat    <= '0;
      r_wb_enable <= 1'b0;
      r_wb_data   <= '0;
      r_rd_id     <= '0;
      r_is_halted <= 1'b0;
    end else begin
      r_wb_enable <= 1'b0;
      r_wb_data   <= '0;
      r_rd_id     <= '0;
      r_is_halted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_enable_in) begin
            r_addr     <= alu_output_in;
            r_wdata    <= rs2_in;
            r_write    <= mem_write_in;
            r_wb_lat   <= wb_enable_in;
            r_halt_lat <= is_halted_in;
            r_rd_lat   <= rd_id_in;
            r_state    <= S_REQ;
          end else begin
            r_wb_enable <= wb_enable_in;
            r_wb_data   <= alu_output_in;
            r_rd_id     <= rd_id_in;
            r_is_halted <= is_halted_in;
          end
        end
        S_REQ: begin
          if (dmem.dmem_req_ready) begin
            r_state <= r_write ? S_DONE : S_RESP;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_RESP: begin
          if (dmem.dmem_resp_valid) begin
            r_rdata <= dmem.dmem_resp_rdata;
            r_state <= S_DONE;
          end else if (w_expired) begin
            r_rdata <= '0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_DONE: begin
          r_wb_enable <= r_wb_lat;
          r_wb_data   <= r_write ? r_addr : r_rdata;
          r_rd_id     <= r_rd_lat;
          r_is_halted <= r_halt_lat;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req_valid = (r_state == S_REQ);
  assign dmem.dmem_req_write = r_write;
  assign dmem.dmem_req_addr  = r_addr;
  assign dmem.dmem_req_wdata = r_wdata;

  // Gated by reset so the stall drops the moment reset asserts.
  assign mem_stall = reset & ((r_state == S_REQ) | (r_state == S_RESP) |
                              ((r_state == S_IDLE) & mem_enable_in));

  assign wb_enable = r_wb_enable;
  assign wb_data   = r_wb_data;
  assign rd_id     = r_rd_id;
  assign is_halted = r_is_halted;
endmodule
